fb_write_scheduler: RTL

Shares the single framebuffer write port (`fb_enable`, `xy_addr`, `color` of the VGA controller) between two requesters. The first is CPU pixel stores from the memory-mapped I/O path. The second is a hardware rectangle-fill engine that walks a rectangle in raster order. The block sits between the pipeline's store path and the VGA controller, and guarantees the fill engine forward progress under sustained CPU traffic.

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_fill_walker.sv | 121 ++++++++++++
 rtl/fb_write_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and constants for the framebuffer write scheduler
// Purpose: framebuffer geometry constants, coordinate/colour types, fill FSM
//          state encoding and a coordinate clamp helper.
// Ports:   none (package).
package fb_pkg;

  localparam int FB_ADDR_W  = 16;
  localparam int FB_COLOR_W = 24;
  localparam int FB_VIS_W   = 200;
  localparam int FB_VIS_H   = 150;

  typedef logic [7:0]            fb_coord_t;
  typedef logic [FB_COLOR_W-1:0] fb_color_t;

  typedef enum logic {
    F_IDLE,
    F_RUN
  } fill_state_t;

  function automatic fb_coord_t fb_clamp(input fb_coord_t v, input fb_coord_t lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/fb_fill_walker.sv
// rtl/fb_fill_walker.sv - rectangle fill walker, raster-order pixel generator
// Purpose: latches a fill command and walks its pixels in raster order, one
//          pixel per step, reporting completion on the cycle it finishes.
// Config:  FB_CLIP_EN clamps latched corners to the visible 200x150 area.
// Ports:   clk, reset_n     clock, async active-low reset
//          start, x0..y1    fill command strobe and inclusive corners
//          color_in         fill colour to latch
//          step             current pixel is consumed this cycle
//          busy             walker in F_RUN (registered state)
//          cur_x, cur_y     current pixel coordinate
//          color            latched fill colour
//          done             combinational: fill finishes this cycle
//                           (last pixel stepped, or empty command accepted)
module fb_fill_walker
  import fb_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      start,
  input  fb_coord_t x0,
  input  fb_coord_t y0,
  input  fb_coord_t x1,
  input  fb_coord_t y1,
  input  fb_color_t color_in,
  input  logic      step,
  output logic      busy,
  output fb_coord_t cur_x,
  output fb_coord_t cur_y,
  output fb_color_t color,
  output logic      done
);

  fill_state_t state_q, state_d;
  fb_coord_t   x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
  fb_coord_t   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  fb_color_t   color_q, color_d;
  fb_coord_t   lx0, ly0, lx1, ly1;

`ifdef FB_CLIP_EN
  assign lx0 = fb_clamp(x0, fb_coord_t'(FB_VIS_W - 1));
  assign lx1 = fb_clamp(x1, fb_coord_t'(FB_VIS_W - 1));
  assign ly0 = fb_clamp(y0, fb_coord_t'(FB_VIS_H - 1));
  assign ly1 = fb_clamp(y1, fb_coord_t'(FB_VIS_H - 1));
`else
  assign lx0 = x0;
  assign lx1 = x1;
  assign ly0 = y0;
  assign ly1 = y1;
`endif

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    color_d = color_q;
    done    = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (start) begin
          if ((lx1 < lx0) || (ly1 < ly0)) begin
            // empty rectangle: report completion without entering F_RUN
            done = 1'b1;
          end else begin
            x0_d    = lx0;
            x1_d    = lx1;
            y1_d    = ly1;
            cur_x_d = lx0;
            cur_y_d = ly0;
            color_d = color_in;
            state_d = F_RUN;
          end
        end
      end
      F_RUN: begin
        if (step) begin
          if (cur_x_q == x1_q) begin
            if (cur_y_q == y1_q) begin
              done    = 1'b1;
              state_d = F_IDLE;
            end else begin
              cur_x_d = x0_q;
              cur_y_d = cur_y_q + 8'd1;
            end
          end else begin
            cur_x_d = cur_x_q + 8'd1;
          end
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= F_IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      color_q <= color_d;
    end
  end

  assign busy  = (state_q == F_RUN);
  assign cur_x = cur_x_q;
  assign cur_y = cur_y_q;
  assign color = color_q;

endmodule

// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - arbitrates CPU pixel stores and fill engine onto the framebuffer port
// Purpose: CPU-priority arbiter with a bounded CPU burst so a pending fill
//          always progresses; registers the framebuffer write port.
// Config:  FB_CLIP_EN drops CPU writes outside the visible 200x150 area
//          (handshake still completes) and clamps fill corners.
// Ports:   clk, reset_n                  clock, async active-low reset
//          cpu_valid/cpu_ready           CPU store handshake (ready is combinational)
//          cpu_addr, cpu_color           {y,x} address and {B,G,R} colour
//          fill_start, fill_x0..fill_y1  fill command and inclusive corners
//          fill_color                    fill colour
//          fill_busy, fill_done          fill status (registered)
//          fb_enable, xy_addr, color     framebuffer write port (registered)
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int CPU_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  input  logic [FB_ADDR_W-1:0]  cpu_addr,
  input  logic [FB_COLOR_W-1:0] cpu_color,
  input  logic                  fill_start,
  input  logic [7:0]            fill_x0,
  input  logic [7:0]            fill_y0,
  input  logic [7:0]            fill_x1,
  input  logic [7:0]            fill_y1,
  input  logic [FB_COLOR_W-1:0] fill_color,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  fb_enable,
  output logic [FB_ADDR_W-1:0]  xy_addr,
  output logic [FB_COLOR_W-1:0] color
);

  localparam int              RUN_W   = $clog2(CPU_BURST + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CPU_BURST);

  logic                  fill_run, walk_done;
  fb_coord_t             cur_x, cur_y;
  fb_color_t             walk_color;
  logic                  cpu_grant, fill_grant, cpu_visible;

  logic [RUN_W-1:0]      cpu_run_q, cpu_run_d;
  logic                  fb_enable_q, fb_enable_d;
  logic [FB_ADDR_W-1:0]  xy_addr_q, xy_addr_d;
  logic [FB_COLOR_W-1:0] color_q, color_d;
  logic                  fill_done_q, fill_done_d;

  fb_fill_walker u_walker (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (fill_start),
    .x0       (fill_x0),
    .y0       (fill_y0),
    .x1       (fill_x1),
    .y1       (fill_y1),
    .color_in (fill_color),
    .step     (fill_grant),
    .busy     (fill_run),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .color    (walk_color),
    .done     (walk_done)
  );

`ifdef FB_CLIP_EN
  assign cpu_visible = (cpu_addr[7:0] < 8'(FB_VIS_W)) && (cpu_addr[15:8] < 8'(FB_VIS_H));
`else
  assign cpu_visible = 1'b1;
`endif

  // After CPU_BURST back-to-back CPU grants during a fill, the CPU is held
  // off for one cycle so the fill takes the port.
  assign cpu_ready  = !(fill_run && (cpu_run_q == RUN_MAX));
  assign cpu_grant  = cpu_valid && cpu_ready;
  assign fill_grant = fill_run && !cpu_grant;

  always_comb begin
    cpu_run_d   = cpu_run_q;
    fb_enable_d = 1'b0;
    xy_addr_d   = xy_addr_q;
    color_d     = color_q;
    fill_done_d = walk_done;

    if (!fill_run || fill_grant) begin
      cpu_run_d = '0;
    end else if (cpu_grant && (cpu_run_q != RUN_MAX)) begin
      cpu_run_d = cpu_run_q + RUN_W'(1);
    end

    if (cpu_grant) begin
      fb_enable_d = cpu_visible;
      xy_addr_d   = cpu_addr;
      color_d     = cpu_color;
    end else if (fill_grant) begin
      fb_enable_d = 1'b1;
      xy_addr_d   = {cur_y, cur_x};
      color_d     = walk_color;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_run_q   <= '0;
      fb_enable_q <= 1'b0;
      xy_addr_q   <= '0;
      color_q     <= '0;
      fill_done_q <= 1'b0;
    end else begin
      cpu_run_q   <= cpu_run_d;
      fb_enable_q <= fb_enable_d;
      xy_addr_q   <= xy_addr_d;
      color_q     <= color_d;
      fill_done_q <= fill_done_d;
    end
  end

  assign fill_busy = fill_run;
  assign fill_done = fill_done_q;
  assign fb_enable = fb_enable_q;
  assign xy_addr   = xy_addr_q;
  assign color     = color_q;

endmodule
